// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, loader and memory-side signals of the
// instruction-memory port arbiter.
//   slave  : the arbiter's view
//   master : the environment's view (fetch stage, loader, memory array)
interface imem_port_arbiter_if #(
   parameter int ADDR_W = 8
);
   // fetch requester
   logic              fetch_req;
   logic [31:0]       fetch_addr;
   logic              fetch_ready;
   logic              fetch_valid;
   logic [31:0]       fetch_instr;
   logic              fetch_err;
   // program loader
   logic              load_valid;
   logic [ADDR_W-1:0] load_addr;
   logic [31:0]       load_data;
   logic              load_ready;
   // memory array
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
      output fetch_ready, fetch_valid, fetch_instr, fetch_err, load_ready,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output fetch_req, fetch_addr, load_valid, load_addr, load_data, mem_rdata,
      input  fetch_ready, fetch_valid, fetch_instr, fetch_err, load_ready,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-port sync-read instruction memory
// between the fetch stage (reads) and the program loader (writes).
// Loader has priority but is capped at MAX_LOAD_BURST consecutive grants
// while a fetch waits. Misaligned/out-of-range fetches return NOP_INSTR with
// fetch_err and never touch the memory. Read latency is exactly one cycle.
// Optional: define IMEM_ARB_LOAD_COUNT_EN to add load_count / fault_seen.
module imem_port_arbiter #(
   parameter int          ADDR_W         = 8,
   parameter int          MAX_LOAD_BURST = 4,
   parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef IMEM_ARB_LOAD_COUNT_EN
   output logic [15:0]          load_count,
   output logic                 fault_seen,
`endif
   imem_port_arbiter_if.slave   bus
);

   localparam logic [3:0] MAX_B = 4'(MAX_LOAD_BURST);

   logic [3:0]  burst_cnt;
   logic        load_gnt;
   logic        fetch_gnt;
   logic        addr_ok;
   logic        rd_pend;   // valid read issued last cycle, data on mem_rdata
   logic        flt_pend;  // faulted fetch granted last cycle
   logic [31:0] instr_q;   // last delivered instruction (hold value)

   // Grant decision: loader first unless its burst cap is hit with a fetch waiting.
   always_comb begin
      load_gnt  = bus.load_valid && ((burst_cnt < MAX_B) || !bus.fetch_req);
      fetch_gnt = bus.fetch_req && !load_gnt;
      addr_ok   = (bus.fetch_addr[1:0] == 2'b00) &&
                  (bus.fetch_addr[31:ADDR_W+2] == '0);
   end

   assign bus.load_ready  = load_gnt;
   assign bus.fetch_ready = fetch_gnt;

   // Memory port drive; idle cycles park everything at zero.
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (load_gnt) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = 1'b1;
         bus.mem_addr  = bus.load_addr;
         bus.mem_wdata = bus.load_data;
      end else if (fetch_gnt && addr_ok) begin
         bus.mem_en   = 1'b1;
         bus.mem_addr = bus.fetch_addr[ADDR_W+1:2];
      end
   end

   // Burst counter: counts loader wins over a waiting fetch, saturating at the cap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         burst_cnt <= '0;
      else if (!bus.fetch_req || fetch_gnt)
         burst_cnt <= '0;
      else if (load_gnt && (burst_cnt < MAX_B))
         burst_cnt <= burst_cnt + 4'd1;
   end

   // Response tracking: one-cycle read/fault pipeline plus the hold register.
   // A fault granted in the same cycle a read returns wins the hold register,
   // because the fault response is the one shown next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend  <= 1'b0;
         flt_pend <= 1'b0;
         instr_q  <= '0;
      end else begin
         rd_pend  <= fetch_gnt && addr_ok;
         flt_pend <= fetch_gnt && !addr_ok;
         if (fetch_gnt && !addr_ok)
            instr_q <= NOP_INSTR;
         else if (rd_pend)
            instr_q <= bus.mem_rdata;
      end
   end

   // Read data passes straight through in the response cycle so latency stays one.
   assign bus.fetch_valid = rd_pend | flt_pend;
   assign bus.fetch_err   = flt_pend;
   assign bus.fetch_instr = rd_pend ? bus.mem_rdata : instr_q;

`ifdef IMEM_ARB_LOAD_COUNT_EN
   // Loader grant counter (wraps) and sticky fault flag, visible with the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_count <= '0;
         fault_seen <= 1'b0;
      end else begin
         if (load_gnt)
            load_count <= load_count + 16'd1;
         if (fetch_gnt && !addr_ok)
            fault_seen <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: scoreboard bench. Expected fetch responses are pushed
// when a fetch is accepted and popped when fetch_valid appears; a reference
// copy of the memory is kept from accepted loader writes.
`timescale 1ns/1ps
module tb_imem_port_arbiter;

   localparam int ADDR_W = 8;

   typedef struct {
      logic        err;
      logic [31:0] instr;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];

   logic [31:0] mem     [0:(1<<ADDR_W)-1];
   logic [31:0] ref_mem [0:(1<<ADDR_W)-1];

   imem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus();

`ifdef IMEM_ARB_LOAD_COUNT_EN
   logic [15:0] load_count;
   logic        fault_seen;
`endif

   imem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_LOAD_BURST(4), .NOP_INSTR(32'h0000_0013)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef IMEM_ARB_LOAD_COUNT_EN
      .load_count (load_count),
      .fault_seen (fault_seen),
`endif
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // memory array model
   always @(posedge clk)
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= mem[bus.mem_addr];
      end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // response monitor
   always @(negedge clk) begin
      if (!rst && bus.fetch_valid) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_cyc",   cyc,           e.cyc);
            chk("rsp_err",   bus.fetch_err, {31'd0, e.err});
            chk("rsp_instr", bus.fetch_instr, e.instr);
         end
      end
   end

   // One cycle of stimulus; returns at the negedge with grants recorded.
   task automatic step(input logic fr, input logic [31:0] fa,
                       input logic lv, input logic [ADDR_W-1:0] la, input logic [31:0] ld);
      exp_t e;
      @(posedge clk); #1;
      bus.fetch_req  = fr;
      bus.fetch_addr = fa;
      bus.load_valid = lv;
      bus.load_addr  = la;
      bus.load_data  = ld;
      @(negedge clk);
      if (bus.fetch_ready) begin
         e.err   = (fa[1:0] != 2'b00) || (fa[31:10] != 22'd0);
         e.instr = e.err ? 32'h0000_0013 : ref_mem[fa[9:2]];
         e.cyc   = cyc + 1;
         exp_q.push_back(e);
      end
      if (bus.load_ready) ref_mem[la] = ld;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, '0, 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      bus.fetch_req = 1'b0; bus.load_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("rst_valid", bus.fetch_valid, 32'd0);
      chk("rst_err",   bus.fetch_err,   32'd0);
      chk("rst_instr", bus.fetch_instr, 32'd0);
      chk("rst_mem_en", bus.mem_en,     32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Loader and fetch both held high; pat[i]=1 means loader grant expected.
   task automatic contend(input int n, input logic [15:0] pat, input logic [31:0] fa,
                          input logic [ADDR_W-1:0] la0);
      logic [ADDR_W-1:0] la;
      logic [31:0]       ld;
      la = la0;
      ld = $urandom;
      for (int i = 0; i < n; i++) begin
         step(1'b1, fa, 1'b1, la, ld);
         chk("cont_load",  bus.load_ready,  {31'd0, pat[i]});
         chk("cont_fetch", bus.fetch_ready, {31'd0, !pat[i]});
         if (bus.load_ready) begin
            la = la + 1'b1;
            ld = $urandom;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < (1<<ADDR_W); i++) begin
         mem[i] = 32'd0;
         ref_mem[i] = 32'd0;
      end
      bus.mem_rdata  = 32'd0;
      bus.fetch_req  = 1'b0; bus.fetch_addr = 32'd0;
      bus.load_valid = 1'b0; bus.load_addr  = '0; bus.load_data = 32'd0;

      // reset state
      @(negedge clk);
      chk("rst0_valid", bus.fetch_valid, 32'd0);
      chk("rst0_err",   bus.fetch_err,   32'd0);
      chk("rst0_instr", bus.fetch_instr, 32'd0);
      chk("rst0_mem_en", bus.mem_en,     32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // idle outputs
      idle(1);
      chk("idle_fready", bus.fetch_ready, 32'd0);
      chk("idle_lready", bus.load_ready,  32'd0);
      chk("idle_addr",   {24'd0, bus.mem_addr}, 32'd0);
      chk("idle_wdata",  bus.mem_wdata,   32'd0);

      // loader writes
      step(1'b0, 32'd0, 1'b1, 8'd5, 32'hDEAD_BEEF);
      chk("ld_ready", bus.load_ready, 32'd1);
      chk("ld_en",    bus.mem_en,     32'd1);
      chk("ld_we",    bus.mem_we,     32'd1);
      chk("ld_addr",  {24'd0, bus.mem_addr}, 32'd5);
      chk("ld_wdata", bus.mem_wdata,  32'hDEAD_BEEF);
      step(1'b0, 32'd0, 1'b1, 8'd0,   32'h1111_0000);
      step(1'b0, 32'd0, 1'b1, 8'd1,   32'h2222_0004);
      step(1'b0, 32'd0, 1'b1, 8'd2,   32'h3333_0008);
      step(1'b0, 32'd0, 1'b1, 8'd255, 32'hCAFE_F00D);

      // single fetch of word 5
      step(1'b1, 32'h14, 1'b0, '0, 32'd0);
      chk("f_ready", bus.fetch_ready, 32'd1);
      chk("f_en",    bus.mem_en,      32'd1);
      chk("f_we",    bus.mem_we,      32'd0);
      chk("f_addr",  {24'd0, bus.mem_addr}, 32'd5);
      idle(1);
      idle(1);
      chk("hold_instr", bus.fetch_instr, 32'hDEAD_BEEF);

      // back-to-back fetches
      step(1'b1, 32'h0, 1'b0, '0, 32'd0);
      step(1'b1, 32'h4, 1'b0, '0, 32'd0);
      step(1'b1, 32'h8, 1'b0, '0, 32'd0);
      idle(2);

      // highest legal word, then faults
      step(1'b1, 32'h3FC, 1'b0, '0, 32'd0);
      chk("top_en", bus.mem_en, 32'd1);
      step(1'b1, 32'h400, 1'b0, '0, 32'd0);
      chk("oor_ready", bus.fetch_ready, 32'd1);
      chk("oor_en",    bus.mem_en,      32'd0);
      step(1'b1, 32'h6, 1'b0, '0, 32'd0);
      chk("mis_en", bus.mem_en, 32'd0);
      idle(2);

      // contention: 4 loads then 1 fetch, repeating; fetch reads a word just written
      contend(10, 16'b0000_0011_1101_111, 32'h50, 8'd20);
      idle(2);

      // reset mid-read: response dropped
      step(1'b1, 32'h14, 1'b0, '0, 32'd0);
      do_reset();
      idle(2);

      // burst counter cleared by reset
      contend(2, 16'h0003, 32'h80, 8'd40);
      do_reset();
      contend(5, 16'h000F, 32'h80, 8'd60);
      idle(2);

`ifdef IMEM_ARB_LOAD_COUNT_EN
      do_reset();
      step(1'b0, 32'd0, 1'b1, 8'd7, 32'h7);
      step(1'b0, 32'd0, 1'b1, 8'd8, 32'h8);
      step(1'b0, 32'd0, 1'b1, 8'd9, 32'h9);
      idle(1);
      chk("load_count", {16'd0, load_count}, 32'd3);
      chk("fault_clr",  {31'd0, fault_seen}, 32'd0);
      step(1'b1, 32'h401, 1'b0, '0, 32'd0);
      idle(3);
      chk("fault_seen", {31'd0, fault_seen}, 32'd1);
      do_reset();
      chk("fault_rst",  {31'd0, fault_seen}, 32'd0);
      chk("count_rst",  {16'd0, load_count}, 32'd0);
`endif

      chk("q_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one single-port, synchronous-read instruction memory between two requesters:
  - the core's fetch stage (read-only);
  - a program loader (write-only).
- Sits between the fetch logic / loader and the memory array.
- Handles arbitration with starvation protection, address checking and read-response timing.

Parameters:
- ADDR_W, 8, word-index width of the memory (depth = 2^ADDR_W words).
- MAX_LOAD_BURST, 4, max consecutive loader grants while a fetch waits (range 1..15).
- NOP_INSTR, 32'h00000013, instruction returned on a faulted fetch.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request valid.
- fetch_addr  in  32  byte address (PC).
- fetch_ready  out  1  fetch request accepted this cycle.
- fetch_valid  out  1  response valid (one-cycle pulse).
- fetch_instr  out  32  response instruction.
- fetch_err  out  1  response is a fault (misaligned or out of range).
- load_valid  in  1  loader write request.
- load_addr  in  ADDR_W  word index to write.
- load_data  in  32  word to write.
- load_ready  out  1  loader write accepted this cycle.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word index.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset:
  - rst is asynchronous, active-high.
  - All registered state clears: fetch_valid=0, fetch_err=0, fetch_instr=0, burst counter=0, pending-read flag=0.
  - Reset mid-read drops the in-flight response; no fetch_valid follows.
- Combinational outputs: fetch_ready, load_ready, mem_en, mem_we, mem_addr, mem_wdata.
- Grant rules, evaluated each cycle:
  - Loader wins if load_valid and burst counter < MAX_LOAD_BURST.
  - Otherwise fetch wins if fetch_req.
  - Otherwise the loader wins if load_valid (no fetch is waiting, so the cap does not apply).
  - At most one of fetch_ready / load_ready is high in a cycle.
- Burst counter:
  - Increments on each loader grant while fetch_req=1, saturating at MAX_LOAD_BURST.
  - Clears on a fetch grant, or on any cycle with fetch_req=0.
- Loader grant: mem_en=1, mem_we=1, mem_addr=load_addr, mem_wdata=load_data.
- Fetch grant, valid address (fetch_addr[1:0]==0 and fetch_addr[31:ADDR_W+2]==0):
  - Cycle N: mem_en=1, mem_we=0, mem_addr=fetch_addr[ADDR_W+1:2].
  - Cycle N+1: fetch_valid=1, fetch_instr=mem_rdata, fetch_err=0.
  - Latency is exactly 1 cycle.
- Fetch grant, faulted address:
  - Memory is not accessed (mem_en=0).
  - Cycle N+1: fetch_valid=1, fetch_err=1, fetch_instr=NOP_INSTR.
- Throughput: back-to-back fetch grants give one response per cycle; there is no response backpressure.
- Idle outputs: when no grant, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- fetch_instr holds its last value when fetch_valid=0.
- Same-cycle write and read (loader writes address A while fetch waits for A): the fetch is granted later and returns the new data.
- Highest valid word (fetch_addr = 4*(2^ADDR_W - 1)) is legal; the next word address faults.

Optional Feature:
- Macro: IMEM_ARB_LOAD_COUNT_EN.
- When defined:
  - Adds output load_count (16 bits), incremented on every loader grant, wrapping 16'hFFFF -> 0.
  - Adds output fault_seen (1 bit), set on any faulted fetch response and cleared only by rst.
  - Both reset to 0.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Fetch only: write 0xDEADBEEF at word 5 via loader, then fetch_addr=0x14 -> fetch_valid one cycle later, fetch_instr=0xDEADBEEF, fetch_err=0.
- Contention, MAX_LOAD_BURST=4: load_valid and fetch_req held high together -> 4 loader grants, then 1 fetch grant, repeating.
- Faults: fetch_addr=0x6 and fetch_addr=0x400 (ADDR_W=8) -> fetch_err=1, fetch_instr=0x00000013, mem_en stays 0.
- Back-to-back fetches: addresses 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive fetch_valid pulses, in order, with matching data.
- Reset: assert rst in the cycle after a fetch grant -> no fetch_valid, all outputs 0, burst counter 0.
- IMEM_ARB_LOAD_COUNT_EN defined: 3 loader writes -> load_count=3; one faulted fetch -> fault_seen=1 until rst.
